// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the CPU data-side memory: decode regions, MMIO offsets, STATUS layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_mmio_pkg;

  // Which target a CPU data address selects.
  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_MMIO = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  // Register offsets inside the 16-byte MMIO window, as word index addr[3:2].
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLES = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS register bit positions.
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  // Assemble the STATUS word from its fields.
  function automatic logic [31:0] build_status(input logic [7:0] count,
                                               input logic       overflow,
                                               input logic       empty,
                                               input logic       full);
    logic [31:0] s;
    s = '0;
    s[STATUS_COUNT_LSB +: 8] = count;
    s[STATUS_OVF_BIT]        = overflow;
    s[STATUS_EMPTY_BIT]      = empty;
    s[STATUS_FULL_BIT]       = full;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_mmio_fifo.sv
// Synchronous FIFO holding the debug TX byte stream.
// Latency: pushed entry visible at the head the cycle after the push edge.
// Backpressure: push is accepted when not full, or when full and a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue can still take a byte when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = store[rd_ptr];

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) store[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// CPU data-side memory: word RAM plus a 16-byte MMIO window (TX byte queue, status, cycle counter).
// Latency: loads combinational (0 cycles); stores commit on the rising edge.
// Backpressure: none toward the CPU; TX pushes into a full queue without a same-edge pop are dropped and flagged.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 16384,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_write,
  output logic [31:0] data_mem_read,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   cycles;
  logic          overflow;
  region_e       region;
  logic [1:0]    mmio_off;
  logic [IDX_W-1:0] ram_idx;

  logic          st_ok;
  logic          st_ram;
  logic          st_tx;
  logic          st_status;
  logic          st_cycles;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          tx_pop;
  logic [31:0]   status_word;

  // Byte-offset bits never select anything: the port is word-access only.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_mem_addr[1:0];

  assign mmio_off = data_mem_addr[3:2];
  assign ram_idx  = data_mem_addr[IDX_W+1:2];

  // Address decode: RAM at the bottom, a single 16-byte MMIO window, everything else unmapped.
  always_comb begin
    region = REGION_NONE;
    if ({1'b0, data_mem_addr} < RAM_BYTES) begin
      region = REGION_RAM;
    end else if (data_mem_addr[31:4] == MMIO_BASE[31:4]) begin
      region = REGION_MMIO;
    end
  end

  // Stores issued while reset is asserted have no effect anywhere.
  assign st_ok     = mem_write && !rst;
  assign st_ram    = st_ok && (region == REGION_RAM);
  assign st_tx     = st_ok && (region == REGION_MMIO) && (mmio_off == OFF_TXDATA);
  assign st_status = st_ok && (region == REGION_MMIO) && (mmio_off == OFF_STATUS);
  assign st_cycles = st_ok && (region == REGION_MMIO) && (mmio_off == OFF_CYCLES);

  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (st_tx),
    .push_dat (data_mem_write[7:0]),
    .pop      (tx_pop),
    .pop_dat  (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // RAM word write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (st_ram) mem[ram_idx] <= data_mem_write;
  end

  // Free-running cycle counter; a store to CYCLES zeroes it in place of that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else if (st_cycles) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // Sticky overflow: set by a dropped push, cleared by any store to STATUS.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (st_status) begin
      overflow <= 1'b0;
    end else if (st_tx && fifo_full && !tx_pop) begin
      overflow <= 1'b1;
    end
  end

  assign status_word = build_status(8'(fifo_count), overflow, fifo_empty, fifo_full);

  // Load mux: reflects pre-edge state, so a load never sees a store from its own cycle.
  always_comb begin
    data_mem_read = '0;
    case (region)
      REGION_RAM: data_mem_read = mem[ram_idx];
      REGION_MMIO: begin
        case (mmio_off)
          OFF_STATUS: data_mem_read = status_word;
          OFF_CYCLES: data_mem_read = cycles;
          default:    data_mem_read = '0;
        endcase
      end
      default: data_mem_read = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

  localparam int          DEPTH = 8;
  localparam logic [31:0] A_TXD = 32'hFFFF_0000;
  localparam logic [31:0] A_STA = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;
  localparam logic [31:0] A_RSV = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_write;
  logic [31:0] data_mem_read;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  data_mem_mmio dut (
    .clk            (clk),
    .rst            (rst),
    .mem_write      (mem_write),
    .data_mem_addr  (data_mem_addr),
    .data_mem_write (data_mem_write),
    .data_mem_read  (data_mem_read),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: RAM words written so far, TX byte queue, overflow flag, cycle count.
  logic [31:0] m_mem [int];
  byte unsigned m_q[$];
  bit          m_ovf;
  logic [31:0] m_cyc;

  function automatic bit in_ram(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == 32'hFFFF_0000;
  endfunction

  // Expected load value; returns 0 when the location holds nothing known yet.
  function automatic bit exp_read(input logic [31:0] a, output logic [31:0] e);
    int w;
    e = 32'h0;
    if (in_ram(a)) begin
      w = int'(a >> 2);
      if (!m_mem.exists(w)) return 1'b0;
      e = m_mem[w];
    end else if (in_mmio(a)) begin
      case ((a >> 2) & 3)
        1: e = (32'(m_q.size()) << 8) | (m_ovf ? 32'h4 : 32'h0)
               | ((m_q.size() == 0) ? 32'h2 : 32'h0)
               | ((m_q.size() == DEPTH) ? 32'h1 : 32'h0);
        2: e = m_cyc;
        default: e = 32'h0;
      endcase
    end
    return 1'b1;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input string tag);
    logic [31:0] e;
    bit popped;
    rst = r;
    mem_write = we;
    data_mem_addr = a;
    data_mem_write = d;
    tx_ready = rdy;
    #1;
    if (exp_read(a, e)) chk({tag, "_rd"}, data_mem_read, e);
    chk({tag, "_vld"}, 32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, "_txd"}, 32'(tx_data), 32'(m_q[0]));
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 32'h0;
    end else begin
      popped = (m_q.size() != 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (we && in_mmio(a) && ((a >> 2) & 3) == 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      if (we && in_mmio(a) && ((a >> 2) & 3) == 1) m_ovf = 1'b0;
      if (we && in_mmio(a) && ((a >> 2) & 3) == 2) m_cyc = 32'h0;
      else m_cyc = m_cyc + 32'd1;
      if (we && in_ram(a)) m_mem[int'(a >> 2)] = d;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    int rdy_pct;

    rst = 1'b1;
    mem_write = 1'b0;
    data_mem_addr = 32'h0;
    data_mem_write = 32'h0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_q.delete();
    m_ovf = 1'b0;
    m_cyc = 32'h0;
    @(negedge clk);

    // Reset state, counter start value.
    step(0, 0, A_CYC, 0, 0, "rst_cyc");
    step(0, 0, A_STA, 0, 0, "rst_status");
    repeat (5) step(0, 0, A_CYC, 0, 0, "cyc_count");

    // RAM store / load, including a misaligned address in the same word.
    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0, "ram_wr");
    step(0, 0, 32'h10, 0, 0, "ram_rd");
    step(0, 0, 32'h13, 0, 0, "ram_rd13");
    step(0, 1, 32'h0000_FFFC, 32'h1234_5678, 0, "ram_top_wr");
    step(0, 0, 32'h0000_FFFC, 0, 0, "ram_top_rd");
    step(0, 1, 32'h0001_0000, 32'hFFFF_FFFF, 0, "unmap_wr");
    step(0, 0, 32'h0001_0000, 0, 0, "unmap_rd");

    // TX ordering with held-off consumer, then drain.
    step(0, 1, A_TXD, 32'h41, 0, "tx_push");
    step(0, 1, A_TXD, 32'h42, 0, "tx_push");
    step(0, 1, A_TXD, 32'h43, 0, "tx_push");
    step(0, 0, A_STA, 0, 0, "tx_status3");
    step(0, 0, A_TXD, 0, 0, "txdata_rd");
    repeat (4) step(0, 0, A_RSV, 0, 1, "tx_drain");

    // Overflow: nine pushes into an eight-deep queue, then clear.
    for (int i = 0; i < 9; i++) step(0, 1, A_TXD, 32'h60 + i, 0, "ovf_push");
    step(0, 0, A_STA, 0, 0, "ovf_status");
    step(0, 1, A_STA, 0, 0, "ovf_clear");
    step(0, 0, A_STA, 0, 0, "ovf_cleared");

    // Full queue with simultaneous push and pop.
    step(0, 1, A_TXD, 32'h5A, 1, "full_pushpop");
    step(0, 0, A_STA, 0, 0, "full_status");
    repeat (9) step(0, 0, A_STA, 0, 1, "full_drain");

    // Cycle counter clear and wrap.
    step(0, 1, A_CYC, 32'hABCD, 0, "cyc_clear");
    step(0, 0, A_CYC, 0, 0, "cyc_after0");
    step(0, 0, A_CYC, 0, 0, "cyc_after1");
    force dut.cycles = 32'hFFFF_FFFF;
    #1;
    release dut.cycles;
    m_cyc = 32'hFFFF_FFFF;
    step(0, 0, A_CYC, 0, 0, "cyc_max");
    step(0, 0, A_CYC, 0, 0, "cyc_wrap");

    // Reset mid-stream: queue discarded, RAM kept, store in reset cycle ignored.
    for (int i = 0; i < 3; i++) step(0, 1, A_TXD, 32'h70 + i, 0, "mid_push");
    step(1, 1, A_TXD, 32'h99, 0, "mid_rst");
    step(0, 0, A_STA, 0, 0, "mid_status");
    step(0, 0, 32'h10, 0, 0, "mid_ram");
    step(0, 0, 32'h8000_0000, 0, 0, "mid_unmap");
    step(0, 0, A_CYC, 0, 0, "mid_cyc");

    // Randomized traffic across all regions.
    for (int n = 0; n < 1200; n++) begin
      rdy_pct = (n < 600) ? 25 : 75;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
        4, 5:       a = A_TXD;
        6:          a = A_STA | 32'($urandom_range(0, 3));
        7:          a = A_CYC;
        8:          a = A_RSV;
        default:    a = ($urandom % 2 == 1) ? (32'h0001_0000 | ($urandom & 32'h7FFF_FFFF))
                                            : 32'hFFFF_0010;
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, a, $urandom,
           $urandom_range(0, 99) < rdy_pct, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
